// File: rtl/mux_scan_pkg.sv
// mux_scan_pkg: shared state type, mode constants and channel-walk helper for mux_scan_nx1
package mux_scan_pkg;

    typedef enum logic [1:0] {IDLE, CAPTURE, PRESENT} state_t;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    localparam int MAX_CH    = 64;
    localparam int MAX_SEL_W = 6;

    typedef struct packed {
        logic                 found;
        logic [MAX_SEL_W-1:0] idx;
    } next_t;

    // lowest set bit strictly above cur; cur = -1 gives the lowest set bit overall
    function automatic next_t next_ch(input logic [MAX_CH-1:0] mask, input int cur);
        next_t r;
        r = '0;
        for (int i = MAX_CH - 1; i >= 0; i--)
            if (i > cur && mask[i]) r = '{found: 1'b1, idx: MAX_SEL_W'(i)};
        return r;
    endfunction

endpackage

// File: rtl/mux_nx1.sv
// mux_nx1: combinational N:1 selector of WIDTH-bit channels, zero for out-of-range select
module mux_nx1 #(
    parameter int NUM_CH = 8,
    parameter int WIDTH  = 1,
    localparam int SEL_W = $clog2(NUM_CH)
) (
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        out
);

    always_comb begin
        out = '0;
        for (int i = 0; i < NUM_CH; i++)
            if (int'(sel) == i) out = in_data[i*WIDTH +: WIDTH];
    end

endmodule

// File: rtl/mux_scan_nx1.sv
// mux_scan_nx1: registered N:1 mux with manual select and masked ascending channel scan behind valid/ready
module mux_scan_nx1 import mux_scan_pkg::*; #(
    parameter int NUM_CH = 8,
    parameter int WIDTH  = 1,
    localparam int SEL_W = $clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    mode,
    input  logic [NUM_CH-1:0]       ch_mask,
    input  logic                    start,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_ch,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    busy,
    output logic                    done
);

    state_t            state, state_n;
    logic              mode_q;
    logic [NUM_CH-1:0] mask_q;
    logic [SEL_W-1:0]  cur, cur_n;
    logic              done_n, load;
    next_t             first, nxt;
    logic [WIDTH-1:0]  mux_out;

    mux_nx1 #(.NUM_CH(NUM_CH), .WIDTH(WIDTH)) u_mux (
        .in_data(in_data),
        .sel    (cur),
        .out    (mux_out)
    );

    assign busy = state != IDLE;

    always_comb begin
        state_n = state;
        cur_n   = cur;
        done_n  = 1'b0;
        load    = 1'b0;
        first   = next_ch(MAX_CH'(ch_mask), -1);
        nxt     = next_ch(MAX_CH'(mask_q), int'(cur));
        case (state)
            IDLE: if (start) begin
                load = 1'b1;
                if (mode == MODE_MANUAL) begin
                    cur_n   = sel;
                    state_n = CAPTURE;
                end else if (first.found) begin
                    cur_n   = SEL_W'(first.idx);
                    state_n = CAPTURE;
                end else begin
                    done_n = 1'b1;
                end
            end
            CAPTURE: state_n = PRESENT;
            PRESENT: if (out_valid && out_ready) begin
                if (mode_q == MODE_SCAN && nxt.found) begin
                    cur_n   = SEL_W'(nxt.idx);
                    state_n = CAPTURE;
                end else begin
                    done_n  = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cur       <= '0;
            mode_q    <= MODE_MANUAL;
            mask_q    <= '0;
            done      <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            out_valid <= 1'b0;
        end else begin
            state <= state_n;
            cur   <= cur_n;
            done  <= done_n;
            if (load) begin
                mode_q <= mode;
                mask_q <= ch_mask;
            end
            if (state == CAPTURE) begin
                out_data  <= mux_out;
                out_ch    <= cur;
                out_valid <= 1'b1;
            end else if (state == PRESENT && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_scan_nx1.sv
// tb_mux_scan_nx1: scenario-driven self-checking bench with a queue-based reference for the scan order
module tb_mux_scan_nx1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] in_data = '0;
    logic [2:0]  sel = '0;
    logic        mode = 1'b0;
    logic [7:0]  ch_mask = '0;
    logic        start = 1'b0;
    logic [3:0]  out_data;
    logic [2:0]  out_ch;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        busy;
    logic        done;

    logic [23:0] in_data6 = '0;
    logic [2:0]  sel6 = '0;
    logic        mode6 = 1'b0;
    logic [5:0]  mask6 = '0;
    logic        start6 = 1'b0;
    logic [3:0]  out_data6;
    logic [2:0]  out_ch6;
    logic        out_valid6;
    logic        ready6 = 1'b1;
    logic        busy6;
    logic        done6;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mux_scan_nx1 #(.NUM_CH(8), .WIDTH(4)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .sel(sel), .mode(mode), .ch_mask(ch_mask),
        .start(start), .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .done(done)
    );

    mux_scan_nx1 #(.NUM_CH(6), .WIDTH(4)) dut6 (
        .clk(clk), .rst(rst), .in_data(in_data6), .sel(sel6), .mode(mode6), .ch_mask(mask6),
        .start(start6), .out_data(out_data6), .out_ch(out_ch6), .out_valid(out_valid6),
        .out_ready(ready6), .busy(busy6), .done(done6)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] chv(input int i);
        return 4'((in_data >> (4 * i)) & 32'hF);
    endfunction

    task automatic set_ramp();
        for (int i = 0; i < 8; i++) in_data[i*4 +: 4] = 4'(i + 1);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        n_cmp++; if (out_data !== 4'd0) begin n_err++; $display("FAIL reset_data got %0h want 0", out_data); end
        n_cmp++; if (out_ch !== 3'd0) begin n_err++; $display("FAIL reset_ch got %0d want 0", out_ch); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", out_valid); end
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL reset_busy_done got %b%b want 00", busy, done); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_manual();
        set_ramp();
        mode = 1'b0; sel = 3'd5; out_ready = 1'b1; start = 1'b1;
        step();
        start = 1'b0; sel = 3'd1;
        n_cmp++; if (busy !== 1'b1 || out_valid !== 1'b0) begin n_err++; $display("FAIL manual_c1 busy/valid got %b/%b want 1/0", busy, out_valid); end
        step();
        n_cmp++; if (out_valid !== 1'b1 || busy !== 1'b1) begin n_err++; $display("FAIL manual_c2 valid/busy got %b/%b want 1/1", out_valid, busy); end
        n_cmp++; if (out_data !== 4'd6 || out_ch !== 3'd5) begin n_err++; $display("FAIL manual_c2 data/ch got %0d/%0d want 6/5", out_data, out_ch); end
        step();
        n_cmp++; if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin n_err++; $display("FAIL manual_c3 done/busy/valid got %b/%b/%b want 1/0/0", done, busy, out_valid); end
        step();
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL manual_c4 done got %b want 0", done); end
        n_cmp++; if (out_data !== 4'd6 || out_ch !== 3'd5) begin n_err++; $display("FAIL manual_hold data/ch got %0d/%0d want 6/5", out_data, out_ch); end
    endtask

    task automatic test_random_manual();
        for (int n = 0; n < 8; n++) begin
            logic [2:0] s;
            logic [3:0] exp_d;
            in_data = $urandom;
            s = 3'($urandom_range(0, 7));
            exp_d = chv(int'(s));
            mode = 1'b0; sel = s; out_ready = 1'b1; start = 1'b1;
            step();
            start = 1'b0; sel = ~s;
            step();
            n_cmp++; if (out_valid !== 1'b1 || out_data !== exp_d || out_ch !== s) begin n_err++; $display("FAIL rand_manual v/d/ch got %b/%0h/%0d want 1/%0h/%0d", out_valid, out_data, out_ch, exp_d, s); end
            step();
            n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL rand_manual_done got %b want 1", done); end
            step();
        end
    endtask

    task automatic run_scan(input logic [7:0] mask, input bit stall);
        int q[$];
        int dones = 0;
        logic prev_v = 1'b0;
        for (int i = 0; i < 8; i++) if (mask[i]) q.push_back(i);
        mode = 1'b1; ch_mask = mask; out_ready = 1'b1; start = 1'b1;
        step();
        start = 1'b0; ch_mask = ~mask; mode = 1'b0;
        for (int cyc = 0; cyc < 200 && dones == 0; cyc++) begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    n_cmp++; n_err++; $display("FAIL scan_extra got ch %0d want none", out_ch);
                end else begin
                    n_cmp++; if (out_ch !== 3'(q[0]) || out_data !== chv(q[0])) begin n_err++; $display("FAIL scan_sample ch/data got %0d/%0h want %0d/%0h", out_ch, out_data, q[0], chv(q[0])); end
                end
                if (!stall) begin
                    n_cmp++; if (prev_v !== 1'b0) begin n_err++; $display("FAIL scan_rate got back-to-back valid want alternating"); end
                end
            end
            if (done) begin
                dones++;
                n_cmp++; if (q.size() != 0 || busy !== 1'b0) begin n_err++; $display("FAIL scan_done left/busy got %0d/%b want 0/0", q.size(), busy); end
            end else begin
                n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL scan_busy got %b want 1", busy); end
            end
            prev_v = out_valid;
            out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
            step();
        end
        n_cmp++; if (dones != 1) begin n_err++; $display("FAIL scan_done_count got %0d want 1", dones); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL scan_done_pulse got %b want 0", done); end
        out_ready = 1'b1;
    endtask

    task automatic test_scan();
        set_ramp();
        run_scan(8'b1010_0101, 1'b0);
        for (int n = 0; n < 6; n++) begin
            in_data = $urandom;
            run_scan(8'($urandom_range(1, 255)), 1'b1);
        end
    endtask

    task automatic test_backpressure();
        set_ramp();
        mode = 1'b1; ch_mask = 8'b0000_0011; out_ready = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        step();
        for (int k = 0; k < 6; k++) begin
            n_cmp++; if (out_valid !== 1'b1 || out_data !== 4'd1 || out_ch !== 3'd0) begin n_err++; $display("FAIL stall_hold v/d/ch got %b/%0h/%0d want 1/1/0", out_valid, out_data, out_ch); end
            if (k == 1) in_data[3:0] = 4'hF;
            if (k == 5) out_ready = 1'b1;
            step();
        end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL stall_gap valid got %b want 0", out_valid); end
        step();
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 4'd2 || out_ch !== 3'd1) begin n_err++; $display("FAIL stall_next v/d/ch got %b/%0h/%0d want 1/2/1", out_valid, out_data, out_ch); end
        step();
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL stall_done got %b want 1", done); end
        step();
    endtask

    task automatic test_empty_mask();
        int seen_bv = 0;
        mode = 1'b1; ch_mask = 8'h00; out_ready = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL empty_done got %b want 1", done); end
        for (int k = 0; k < 3; k++) begin
            if (busy || out_valid) seen_bv++;
            step();
        end
        n_cmp++; if (seen_bv != 0) begin n_err++; $display("FAIL empty_busy_valid got %0d cycles want 0", seen_bv); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL empty_done_pulse got %b want 0", done); end
    endtask

    task automatic test_six_channel();
        for (int i = 0; i < 6; i++) in_data6[i*4 +: 4] = 4'(9 + i);
        mode6 = 1'b0; sel6 = 3'd7; start6 = 1'b1;
        step();
        start6 = 1'b0;
        step();
        n_cmp++; if (out_valid6 !== 1'b1 || out_data6 !== 4'd0 || out_ch6 !== 3'd7) begin n_err++; $display("FAIL six_oob v/d/ch got %b/%0h/%0d want 1/0/7", out_valid6, out_data6, out_ch6); end
        step();
        sel6 = 3'd4; start6 = 1'b1;
        step();
        start6 = 1'b0;
        step();
        n_cmp++; if (out_data6 !== 4'd13 || out_ch6 !== 3'd4) begin n_err++; $display("FAIL six_ch4 d/ch got %0h/%0d want d/4", out_data6, out_ch6); end
        step();
    endtask

    task automatic test_reset_mid();
        int dn = 0;
        set_ramp();
        mode = 1'b1; ch_mask = 8'hFF; out_ready = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        step();
        rst = 1'b1;
        #1;
        n_cmp++; if (out_valid !== 1'b0 || out_data !== 4'd0 || out_ch !== 3'd0 || busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL mid_reset v/d/ch/b/dn got %b/%0h/%0d/%b/%b want 0/0/0/0/0", out_valid, out_data, out_ch, busy, done); end
        out_ready = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (done || busy || out_valid) dn++;
            step();
        end
        n_cmp++; if (dn != 0) begin n_err++; $display("FAIL mid_reset_quiet got %0d active cycles want 0", dn); end
        mode = 1'b0; sel = 3'd3; start = 1'b1;
        step();
        start = 1'b0;
        step();
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 4'd4 || out_ch !== 3'd3) begin n_err++; $display("FAIL mid_reset_reentry v/d/ch got %b/%0h/%0d want 1/4/3", out_valid, out_data, out_ch); end
        step();
        step();
    endtask

    task automatic test_back_to_back();
        set_ramp();
        mode = 1'b0; sel = 3'd2; out_ready = 1'b1; start = 1'b1;
        step();
        step();
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 4'd3) begin n_err++; $display("FAIL b2b_first v/d got %b/%0h want 1/3", out_valid, out_data); end
        step();
        n_cmp++; if (done !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL b2b_done done/busy got %b/%b want 1/0", done, busy); end
        step();
        start = 1'b0;
        n_cmp++; if (busy !== 1'b1 || out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_restart busy/valid got %b/%b want 1/0", busy, out_valid); end
        step();
        n_cmp++; if (out_valid !== 1'b1 || out_ch !== 3'd2) begin n_err++; $display("FAIL b2b_second v/ch got %b/%0d want 1/2", out_valid, out_ch); end
        step();
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL b2b_second_done got %b want 1", done); end
        step();
    endtask

    initial begin
        test_reset();
        test_manual();
        test_random_manual();
        test_scan();
        test_backpressure();
        test_empty_mask();
        test_six_channel();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
